pipe_spawner: RTL



---
 rtl/pipe_spawner.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pipe_spawner.sv
// Scrolling pipe pool for the bird game: moves, retires, spawns and scores pipes once per frame tick.
// Optional macro PIPE_SPEEDUP_EN raises the scroll speed with the score, up to SPEED_MAX.
//
// state  | meaning
// IDLE   | after reset, pool empty, frame ticks ignored
// RUN    | pool scrolls and spawns on every frame tick
// FREEZE | game over, pool held until the next start
module pipe_spawner #(
  parameter int NUM_PIPES = 4,
  parameter int SCREEN_W  = 640,
  parameter int PIPE_W    = 52,
  parameter int SPACING   = 200,
  parameter int SPEED     = 2,
  parameter int SPEED_MAX = 6,
  parameter int GAP_MIN   = 80,
  parameter int BIRD_X    = 160
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_tick,
  input  logic                    start,
  input  logic                    game_over,
  input  logic [6:0]              rand_in,
  output logic [NUM_PIPES*11-1:0] pipe_x,
  output logic [NUM_PIPES*8-1:0]  gap_y,
  output logic [NUM_PIPES-1:0]    pipe_valid,
  output logic                    running,
  output logic                    pass_pulse,
  output logic [7:0]              score
);

  typedef enum logic [1:0] {IDLE, RUN, FREEZE} state_t;

  localparam logic [10:0] X_SPAWN    = 11'(SCREEN_W + PIPE_W);
  localparam logic [10:0] X_BIRD     = 11'(BIRD_X);
  localparam logic [9:0]  DIST_SPAWN = 10'(SPACING);
  localparam logic [7:0]  GAP_BASE   = 8'(GAP_MIN);
  localparam logic [5:0]  SPD_BASE   = 6'(SPEED);
  localparam logic [5:0]  SPD_CEIL   = 6'(SPEED_MAX);

  state_t                 state_q, state_d;
  logic [10:0]            x_q   [NUM_PIPES];
  logic [10:0]            x_d   [NUM_PIPES];
  logic [7:0]             gap_q [NUM_PIPES];
  logic [7:0]             gap_d [NUM_PIPES];
  logic [NUM_PIPES-1:0]   valid_q, valid_d;
  logic [NUM_PIPES-1:0]   spawn_sel;
  logic [9:0]             dist_q, dist_d, nd;
  logic [7:0]             score_q, score_d;
  logic                   pass_q, pass_d;
  logic                   running_q;
  logic                   pass_any;
  logic                   free_found;
  logic [5:0]             spd;

`ifdef PIPE_SPEEDUP_EN
  logic [5:0] spd_raw;
  assign spd_raw = SPD_BASE + {1'b0, score_q[7:3]};
  assign spd     = (spd_raw > SPD_CEIL) ? SPD_CEIL : spd_raw;
`else
  // Same formula with a zero score term, so the speed is the constant base.
  assign spd = (SPD_BASE > SPD_CEIL) ? SPD_CEIL : SPD_BASE;
`endif

  // Spawn target is chosen from occupancy before this tick's retirements.
  always_comb begin
    spawn_sel  = '0;
    free_found = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (!valid_q[i] && !free_found) begin
        spawn_sel[i] = 1'b1;
        free_found   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    dist_d   = dist_q;
    score_d  = score_q;
    pass_d   = 1'b0;
    pass_any = 1'b0;
    nd       = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      x_d[i]   = x_q[i];
      gap_d[i] = gap_q[i];
    end

    if (start) begin
      state_d = RUN;
      valid_d = '0;
      score_d = '0;
      dist_d  = DIST_SPAWN;
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_d[i]   = '0;
        gap_d[i] = '0;
      end
    end else if (state_q == RUN) begin
      if (game_over) begin
        state_d = FREEZE;
      end else if (frame_tick) begin
        for (int i = 0; i < NUM_PIPES; i++) begin
          if (valid_q[i]) begin
            if (x_q[i] <= {5'b0, spd}) begin
              valid_d[i] = 1'b0;
              x_d[i]     = '0;
            end else begin
              x_d[i] = x_q[i] - {5'b0, spd};
              if (x_q[i] > X_BIRD && x_d[i] <= X_BIRD) pass_any = 1'b1;
            end
          end
        end

        if (pass_any) begin
          pass_d = 1'b1;
          if (score_q != 8'hff) score_d = score_q + 8'd1;
        end

        nd = dist_q + {4'b0, spd};
        if (nd >= DIST_SPAWN) begin
          dist_d = '0;
          for (int i = 0; i < NUM_PIPES; i++) begin
            if (spawn_sel[i]) begin
              valid_d[i] = 1'b1;
              x_d[i]     = X_SPAWN;
              gap_d[i]   = GAP_BASE + {1'b0, rand_in};
            end
          end
        end else begin
          dist_d = nd;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      dist_q    <= '0;
      score_q   <= '0;
      pass_q    <= 1'b0;
      running_q <= 1'b0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_q[i]   <= '0;
        gap_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      dist_q    <= dist_d;
      score_q   <= score_d;
      pass_q    <= pass_d;
      running_q <= (state_d == RUN);
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_q[i]   <= x_d[i];
        gap_q[i] <= gap_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pack
    assign pipe_x[11*g +: 11] = x_q[g];
    assign gap_y[8*g +: 8]    = gap_q[g];
  end

  assign pipe_valid = valid_q;
  assign running    = running_q;
  assign pass_pulse = pass_q;
  assign score      = score_q;

endmodule
